// File: rtl/mvme_job_arbiter.sv
// Purpose : round-robin arbiter sharing one 8-operand MVME MAC between N_REQ requesters;
//           registers the winning operands onto the MVME inputs and returns the tagged result.
// Latency : request accept -> rsp_valid after LAT+1 edges; one job per cycle, responses in issue order.
// Backpres: grant is a combinational one-hot req_ready; no response back-pressure (consumer takes every rsp).
// Ports   : clk/rst (async active-high); enable, flush; req_valid/req_ready/req_op/req_sel per requester;
//           mvme_a..mvme_h operands out; mvme_out_total/ab_cd/ef_gh/overload results in;
//           rsp_valid/rsp_id/rsp_data/rsp_overload response; inflight count and busy flag.
module mvme_job_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 35,
  parameter int LAT   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*8*W-1:0]   req_op,
  input  logic [N_REQ*2-1:0]     req_sel,
  output logic [W-1:0]           mvme_a,
  output logic [W-1:0]           mvme_b,
  output logic [W-1:0]           mvme_c,
  output logic [W-1:0]           mvme_d,
  output logic [W-1:0]           mvme_e,
  output logic [W-1:0]           mvme_f,
  output logic [W-1:0]           mvme_g,
  output logic [W-1:0]           mvme_h,
  input  logic [W-1:0]           mvme_out_total,
  input  logic [W-1:0]           mvme_out_ab_cd,
  input  logic [W-1:0]           mvme_out_ef_gh,
  input  logic                   mvme_overload,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_id,
  output logic [2*W-1:0]         rsp_data,
  output logic                   rsp_overload,
  output logic [3:0]             inflight,
  output logic                   busy
);

  logic [2:0]         rr_ptr;
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   rot;
  logic               win_vld;
  logic [2:0]         winner;
  logic [3:0]         cand;
  logic [8*W-1:0]     win_op;
  logic [1:0]         win_sel;

  // Tag pipe: stage 0 is written at the issue edge, stage LAT lines up with mvme_out_*.
  logic [LAT:0]       tag_vld;
  logic [LAT:0][2:0]  tag_id;
  logic [LAT:0][1:0]  tag_sel;

  // Rotate the eligible vector so bit 0 is the requester at rr_ptr; the first set bit
  // after rotation is the round-robin winner, mapped back by adding rr_ptr mod N_REQ.
  always_comb begin
    eligible = req_valid & {N_REQ{enable & ~flush}};
    rot      = N_REQ'({eligible, eligible} >> rr_ptr);
    win_vld  = 1'b0;
    winner   = '0;
    cand     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!win_vld && rot[off]) begin
        win_vld = 1'b1;
        cand    = {1'b0, rr_ptr} + 4'(off);
        if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
        winner  = cand[2:0];
      end
    end
  end

  // One-hot grant and operand/select mux; zero operands when nobody wins.
  always_comb begin
    req_ready = '0;
    win_op    = '0;
    win_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_vld && winner == 3'(i)) begin
        req_ready[i] = 1'b1;
        win_op       = req_op[i*8*W +: 8*W];
        win_sel      = req_sel[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      {mvme_a, mvme_b, mvme_c, mvme_d, mvme_e, mvme_f, mvme_g, mvme_h} <= '0;
      tag_vld      <= '0;
      tag_id       <= '0;
      tag_sel      <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_overload <= 1'b0;
      inflight     <= '0;
    end else begin
      {mvme_a, mvme_b, mvme_c, mvme_d, mvme_e, mvme_f, mvme_g, mvme_h} <= win_op;
      if (win_vld) rr_ptr <= (winner == 3'(N_REQ-1)) ? 3'd0 : winner + 3'd1;

      // Flush kills every tagged job, including the one about to be reported this edge.
      tag_vld <= flush ? '0 : {tag_vld[LAT-1:0], win_vld};
      tag_id  <= {tag_id[LAT-1:0], winner};
      tag_sel <= {tag_sel[LAT-1:0], win_sel};

      rsp_valid <= tag_vld[LAT] & ~flush;
      if (tag_vld[LAT] && !flush) begin
        rsp_id       <= tag_id[LAT];
        rsp_overload <= mvme_overload;
        case (tag_sel[LAT])
          2'd0:    rsp_data <= {{W{1'b0}}, mvme_out_total};
          2'd1:    rsp_data <= {{W{1'b0}}, mvme_out_ab_cd};
          2'd2:    rsp_data <= {{W{1'b0}}, mvme_out_ef_gh};
          default: rsp_data <= {mvme_out_ef_gh, mvme_out_ab_cd};
        endcase
      end else begin
        rsp_id       <= '0;
        rsp_data     <= '0;
        rsp_overload <= 1'b0;
      end

      // Issue and retire on the same edge cancel out.
      if (flush) inflight <= '0;
      else       inflight <= inflight + {3'd0, win_vld} - {3'd0, tag_vld[LAT]};
    end
  end

  assign busy = (inflight != 4'd0);

endmodule

// File: tb/tb_mvme_job_arbiter.sv
module tb_mvme_job_arbiter;
  localparam int N_REQ = 4;
  localparam int W     = 35;
  localparam int LAT   = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 enable = 1'b0;
  logic                 flush = 1'b0;
  logic [N_REQ-1:0]     req_valid = '0;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*8*W-1:0] req_op = '0;
  logic [N_REQ*2-1:0]   req_sel = '0;
  logic [W-1:0]         mvme_a, mvme_b, mvme_c, mvme_d, mvme_e, mvme_f, mvme_g, mvme_h;
  logic [W-1:0]         mvme_out_total = '0;
  logic [W-1:0]         mvme_out_ab_cd = '0;
  logic [W-1:0]         mvme_out_ef_gh = '0;
  logic                 mvme_overload = 1'b0;
  logic                 rsp_valid;
  logic [2:0]           rsp_id;
  logic [2*W-1:0]       rsp_data;
  logic                 rsp_overload;
  logic [3:0]           inflight;
  logic                 busy;

  mvme_job_arbiter #(.N_REQ(N_REQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sel(req_sel),
    .mvme_a(mvme_a), .mvme_b(mvme_b), .mvme_c(mvme_c), .mvme_d(mvme_d),
    .mvme_e(mvme_e), .mvme_f(mvme_f), .mvme_g(mvme_g), .mvme_h(mvme_h),
    .mvme_out_total(mvme_out_total), .mvme_out_ab_cd(mvme_out_ab_cd),
    .mvme_out_ef_gh(mvme_out_ef_gh), .mvme_overload(mvme_overload),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_overload(rsp_overload), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen at a negedge is the number of posedges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             id;
    logic [2*W-1:0] data;
    logic           ovl;
    int             issue_cyc;
    int             exp_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Requester-side state and reference model state.
  bit         vld [N_REQ];
  logic [W-1:0] op [N_REQ][8];
  logic [1:0] sel [N_REQ];
  bit         frc [N_REQ];
  bit         en = 1'b0;
  bit         fl = 1'b0;
  int         rr = 0;
  logic       force_ovl = 1'b0;

  function automatic logic [W-1:0] prod2(logic [W-1:0] a, logic [W-1:0] b,
                                         logic [W-1:0] c, logic [W-1:0] d);
    longint r;
    r = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c)) * longint'($signed(d));
    return r[W-1:0];
  endfunction

  // Ideal MVME: operands seen after edge k appear on mvme_out_* before edge k+LAT+1.
  logic [W-1:0] p_tot [0:LAT];
  logic [W-1:0] p_ab  [0:LAT];
  logic [W-1:0] p_ef  [0:LAT];
  logic         p_ov  [0:LAT];
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      p_tot[i] = p_tot[i-1];
      p_ab[i]  = p_ab[i-1];
      p_ef[i]  = p_ef[i-1];
      p_ov[i]  = p_ov[i-1];
    end
    p_ab[0]  = prod2(mvme_a, mvme_b, mvme_c, mvme_d);
    p_ef[0]  = prod2(mvme_e, mvme_f, mvme_g, mvme_h);
    p_tot[0] = p_ab[0] + p_ef[0];
    p_ov[0]  = force_ovl;
    mvme_out_total = p_tot[LAT];
    mvme_out_ab_cd = p_ab[LAT];
    mvme_out_ef_gh = p_ef[LAT];
    mvme_overload  = p_ov[LAT];
  end

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [2*W-1:0] exp_data(int i);
    logic [W-1:0] ab, ef, tot;
    ab  = prod2(op[i][0], op[i][1], op[i][2], op[i][3]);
    ef  = prod2(op[i][4], op[i][5], op[i][6], op[i][7]);
    tot = ab + ef;
    case (sel[i])
      2'd0:    return {{W{1'b0}}, tot};
      2'd1:    return {{W{1'b0}}, ab};
      2'd2:    return {{W{1'b0}}, ef};
      default: return {ef, ab};
    endcase
  endfunction

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got id %0d data %0h, required no response (t=%0t)",
                   rsp_id, rsp_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", 128'(cyc), 128'(e.exp_cyc));
          check("rsp_id", 128'(rsp_id), 128'(e.id));
          check("rsp_data", 128'(rsp_data), 128'(e.data));
          check("rsp_overload", 128'(rsp_overload), 128'(e.ovl));
        end
      end
    end
  endtask

  task automatic set_job(int i, int a, int b, int c, int d, int e, int f, int g, int h,
                         logic [1:0] s, bit fo);
    op[i][0] = W'(a); op[i][1] = W'(b); op[i][2] = W'(c); op[i][3] = W'(d);
    op[i][4] = W'(e); op[i][5] = W'(f); op[i][6] = W'(g); op[i][7] = W'(h);
    sel[i] = s;
    frc[i] = fo;
    vld[i] = 1'b1;
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  task automatic rand_job(int i);
    set_job(i, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(),
            2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
  endtask

  task automatic refill(int pct);
    for (int i = 0; i < N_REQ; i++)
      if (!vld[i] && int'($urandom_range(0, 99)) < pct) rand_job(i);
  endtask

  // One clock: check occupancy, drive inputs for the coming edge, predict and check the grant.
  task automatic cycle();
    int n;
    int w;
    logic [N_REQ-1:0] exp_rdy;
    exp_t e;
    exp_t keep[$];
    @(negedge clk);
    n = 0;
    foreach (exp_q[k]) if (exp_q[k].issue_cyc <= cyc && exp_q[k].exp_cyc > cyc) n++;
    check("inflight", 128'(inflight), 128'(n));
    check("busy", 128'(busy), 128'(n != 0));
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i] = vld[i];
      req_sel[i*2 +: 2] = sel[i];
      for (int j = 0; j < 8; j++) req_op[i*8*W + (7-j)*W +: W] = op[i][j];
    end
    enable = en;
    flush  = fl;
    #1;
    w = -1;
    if (en && !fl)
      for (int o = 0; o < N_REQ; o++)
        if (w < 0 && vld[(rr + o) % N_REQ]) w = (rr + o) % N_REQ;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("grant", 128'(req_ready), 128'(exp_rdy));
    force_ovl = 1'b0;
    if (fl) begin
      foreach (exp_q[k]) if (exp_q[k].exp_cyc <= cyc) keep.push_back(exp_q[k]);
      exp_q = keep;
    end
    if (w >= 0) begin
      e.id        = w;
      e.data      = exp_data(w);
      e.ovl       = frc[w];
      e.issue_cyc = cyc + 1;
      e.exp_cyc   = cyc + 2 + LAT;
      exp_q.push_back(e);
      force_ovl = frc[w];
      rr        = (w + 1) % N_REQ;
      vld[w]    = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    req_valid = '0;
    enable = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < N_REQ; i++) vld[i] = 1'b0;
    en = 1'b0;
    fl = 1'b0;
    rr = 0;
    force_ovl = 1'b0;
    exp_q.delete();
    #1;
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_data", 128'(rsp_data), 128'(0));
    check("rst_inflight", 128'(inflight), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_mvme_a", 128'(mvme_a), 128'(0));
    check("rst_mvme_h", 128'(mvme_h), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      vld[i] = 1'b0;
      sel[i] = 2'd0;
      frc[i] = 1'b0;
      for (int j = 0; j < 8; j++) op[i][j] = '0;
    end
    fork
      monitor_loop();
    join_none

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("init_rsp_valid", 128'(rsp_valid), 128'(0));
    check("init_rsp_id", 128'(rsp_id), 128'(0));
    check("init_inflight", 128'(inflight), 128'(0));
    check("init_busy", 128'(busy), 128'(0));
    check("init_mvme_a", 128'(mvme_a), 128'(0));
    rst = 1'b0;
    en  = 1'b1;

    // Single job: 2*3 + 4*5 = 26, response LAT+1 edges after accept.
    set_job(0, 2, 3, 4, 5, 0, 0, 0, 0, 2'd0, 1'b0);
    cycle();
    repeat (LAT + 3) cycle();

    // Full contention from reset: grants rotate 0,1,2,3,... one per cycle.
    do_reset();
    refill(100);
    repeat (12) begin
      cycle();
      refill(100);
    end
    for (int i = 0; i < N_REQ; i++) vld[i] = 1'b0;
    repeat (LAT + 3) cycle();

    // Fairness: move the pointer to 2, then rq1+rq3 pending, rq2 joins mid-stream.
    set_job(1, 1, 1, 1, 1, 1, 1, 1, 1, 2'd0, 1'b0);
    cycle();
    cycle();
    set_job(1, 3, 4, 0, 0, 0, 0, 0, 0, 2'd1, 1'b0);
    set_job(3, 5, 6, 0, 0, 1, 2, 0, 0, 2'd2, 1'b0);
    cycle();
    set_job(2, -7, 8, 9, 10, 0, 0, 0, 0, 2'd0, 1'b0);
    repeat (3) cycle();
    repeat (LAT + 3) cycle();

    // Pair select with forced overload on that job only: {49, 1}.
    set_job(0, 1, 1, 0, 0, 7, 7, 0, 0, 2'd3, 1'b1);
    cycle();
    set_job(1, 2, 2, 0, 0, 3, 3, 0, 0, 2'd3, 1'b0);
    cycle();
    repeat (LAT + 3) cycle();

    // Flush with three jobs in flight, then a fresh job one cycle later.
    rand_job(0); rand_job(1); rand_job(2);
    repeat (3) cycle();
    fl = 1'b1;
    rand_job(3);
    cycle();
    fl = 1'b0;
    cycle();
    cycle();
    repeat (LAT + 3) cycle();

    // enable=0 with two in flight: no grants, both responses still emerge.
    rand_job(0); rand_job(1);
    repeat (2) cycle();
    en = 1'b0;
    refill(100);
    repeat (LAT + 3) cycle();
    en = 1'b1;
    repeat (4) begin
      cycle();
      refill(100);
    end
    // Reset mid-stream: nothing may come out afterwards.
    do_reset();
    repeat (LAT + 4) cycle();

    // Randomized traffic with occasional enable drops, flushes and withdrawn requests.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N_REQ; i++)
        if (vld[i] && $urandom_range(0, 19) == 0) vld[i] = 1'b0;
      refill(40);
      en = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 39) == 0);
      cycle();
    end
    en = 1'b1;
    fl = 1'b0;
    for (int i = 0; i < N_REQ; i++) vld[i] = 1'b0;
    repeat (LAT + 4) cycle();

    check("drain_pending", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
